// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache on the datapath fetch port.
// Misses become single-word fills on the iREN/iaddr/iwait/iload memory port.
module icache_responder #(
    parameter int NSETS = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    input  logic             halt,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [29:0]      fill_word_reg, fill_word_next;
    logic [NSETS-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem  [NSETS];
    logic [31:0]      data_mem [NSETS];
    logic [CNT_W-1:0] hit_count_reg, miss_count_reg;

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             lookup_hit;
    logic             start_fill;
    logic             fill_done;
    logic [NSETS-1:0] frame_we;
    logic             unused_byte_offset;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = fill_word_reg[IDX_W-1:0];
    assign fill_tag = fill_word_reg[29:IDX_W];
    assign unused_byte_offset = ^imemaddr[1:0];

    assign lookup_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_next     = state_reg;
        fill_word_next = fill_word_reg;
        ihit           = 1'b0;
        iREN           = 1'b0;
        iaddr          = '0;
        start_fill     = 1'b0;
        fill_done      = 1'b0;
        case (state_reg)
            IDLE: begin
                ihit = imemREN && lookup_hit && !halt;
                if (imemREN && !halt && !lookup_hit) begin
                    start_fill     = 1'b1;
                    fill_word_next = imemaddr[31:2];
                    state_next     = FILL;
                end
            end
            FILL: begin
                // The latched address is fetched regardless of what the datapath does now
                iREN  = 1'b1;
                iaddr = {fill_word_reg, 2'b00};
                if (!iwait) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imemload = ihit ? data_mem[req_idx] : '0;

    generate
        for (genvar gi = 0; gi < NSETS; gi++) begin : g_frame_we
            assign frame_we[gi] = fill_done && (fill_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            fill_word_reg  <= '0;
            valid_reg      <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            fill_word_reg <= fill_word_next;
            valid_reg     <= valid_reg | frame_we;
            if (ihit && (hit_count_reg != '1))
                hit_count_reg <= hit_count_reg + CNT_W'(1);
            if (start_fill && (miss_count_reg != '1))
                miss_count_reg <= miss_count_reg + CNT_W'(1);
        end
    end

    // Tag/data frames carry no reset; a fill cut short by reset must not land
    always_ff @(posedge CLK) begin
        if (nRST && fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_icache_responder.sv
// Randomized self-checking bench for icache_responder with a table-based cache
// model and a hashed memory image; counters narrowed so saturation is reachable.
module tb_icache_responder;

    localparam int NSETS = 16;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             halt;
    logic             ihit;
    logic [31:0]      imemload;
    logic             iREN;
    logic [31:0]      iaddr;
    logic             iwait;
    logic [31:0]      iload;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    int vectors = 0;
    int errors  = 0;

    bit          mvalid [NSETS];
    logic [29:0] mword  [NSETS];
    int          mhits;
    int          mmisses;

    always #5 CLK = ~CLK;

    icache_responder #(.NSETS(NSETS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .halt(halt),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (errors so far %0d)", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memw(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h40) return 32'h8C010004;
        return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic int frame_of(input logic [31:0] a);
        return int'((a >> 2) % NSETS);
    endfunction

    function automatic bit cached(input logic [31:0] a);
        return mvalid[frame_of(a)] && (mword[frame_of(a)] == a[31:2]);
    endfunction

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NSETS; i++) mvalid[i] = 1'b0;
        mhits   = 0;
        mmisses = 0;
    endfunction

    // One fetch transaction: lookup cycle, fill cycles if it misses, then the re-lookup cycle
    task automatic do_fetch(input logic [31:0] a, input int lat, input bit switch_mid,
                            input logic [31:0] alt);
        bit          exp_hit;
        logic [31:0] want;
        @(negedge CLK);
        imemREN = 1'b1; halt = 1'b0; imemaddr = a; iwait = 1'b1; iload = $urandom;
        #1;
        exp_hit = cached(a);
        want    = memw(a);
        $display("fetch addr=%08h expect_hit=%0d lat=%0d ihit=%0d", a, exp_hit, lat, ihit);
        vectors++; if (hit_count !== CNT_W'(mhits)) begin errors++;
            $display("FAIL hit_count: got %0d want %0d", hit_count, mhits); end
        vectors++; if (miss_count !== CNT_W'(mmisses)) begin errors++;
            $display("FAIL miss_count: got %0d want %0d", miss_count, mmisses); end
        vectors++; if (iREN !== 1'b0) begin errors++;
            $display("FAIL idle_iREN: got %b want 0 addr=%08h", iREN, a); end
        vectors++; if (ihit !== exp_hit) begin errors++;
            $display("FAIL lookup_ihit: got %b want %b addr=%08h", ihit, exp_hit, a); end
        vectors++; if (imemload !== (exp_hit ? want : 32'h0)) begin errors++;
            $display("FAIL lookup_data: got %08h want %08h addr=%08h", imemload,
                     exp_hit ? want : 32'h0, a); end
        if (exp_hit) begin
            mhits = sat(mhits);
            return;
        end
        mmisses = sat(mmisses);
        for (int k = 0; k <= lat; k++) begin
            @(negedge CLK);
            if (switch_mid) imemaddr = alt;
            iwait = (k < lat);
            iload = (k < lat) ? $urandom : want;
            #1;
            vectors++; if (iREN !== 1'b1) begin errors++;
                $display("FAIL fill_iREN: got %b want 1 cycle %0d", iREN, k); end
            vectors++; if (iaddr !== {a[31:2], 2'b00}) begin errors++;
                $display("FAIL fill_iaddr: got %08h want %08h", iaddr, {a[31:2], 2'b00}); end
            vectors++; if (ihit !== 1'b0) begin errors++;
                $display("FAIL fill_ihit: got %b want 0", ihit); end
        end
        mvalid[frame_of(a)] = 1'b1;
        mword[frame_of(a)]  = a[31:2];
        @(negedge CLK);
        iwait = 1'b1; iload = $urandom;
        if (switch_mid) imemREN = 1'b0;
        #1;
        vectors++; if (ihit !== !switch_mid) begin errors++;
            $display("FAIL refetch_ihit: got %b want %b addr=%08h", ihit, !switch_mid, a); end
        if (!switch_mid) begin
            vectors++; if (imemload !== want) begin errors++;
                $display("FAIL refetch_data: got %08h want %08h", imemload, want); end
            mhits = sat(mhits);
        end
        vectors++; if (iREN !== 1'b0) begin errors++;
            $display("FAIL after_fill_iREN: got %b want 0", iREN); end
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; halt = 1'b0; iwait = 1'b1; iload = 32'h0;
        repeat (3) @(negedge CLK);
        imemREN = 1'b0;
        #1;
        vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit: got %b want 0", ihit); end
        vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN: got %b want 0", iREN); end
        vectors++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %08h want 0", iaddr); end
        vectors++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload: got %08h want 0", imemload); end
        vectors++; if (hit_count !== '0) begin errors++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
        vectors++; if (miss_count !== '0) begin errors++; $display("FAIL reset_misses: got %0d want 0", miss_count); end
        model_clear();
        nRST = 1'b1;
    endtask

    task automatic test_cold_fetch();
        do_fetch(32'h40, 2, 1'b0, 32'h0);
        @(negedge CLK); imemREN = 1'b0; #1;
        vectors++; if (miss_count !== CNT_W'(1)) begin errors++;
            $display("FAIL cold_miss_count: got %0d want 1", miss_count); end
    endtask

    task automatic test_repeat_hits();
        for (int i = 0; i < 5; i++) do_fetch(32'h40, 0, 1'b0, 32'h0);
    endtask

    task automatic test_conflict();
        do_fetch(32'h440, 1, 1'b0, 32'h0);
        do_fetch(32'h40, 1, 1'b0, 32'h0);
        @(negedge CLK); imemREN = 1'b0; #1;
        vectors++; if (miss_count !== CNT_W'(3)) begin errors++;
            $display("FAIL conflict_miss_count: got %0d want 3", miss_count); end
    endtask

    task automatic test_addr_change();
        do_fetch(32'h80, 3, 1'b1, 32'h84);
        do_fetch(32'h84, 1, 1'b0, 32'h0);
        do_fetch(32'h80, 0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_fill();
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h3C0; halt = 1'b0; iwait = 1'b1;
        #1;
        vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL rmf_lookup: got %b want 0", ihit); end
        @(negedge CLK); #1;
        vectors++; if (iREN !== 1'b1) begin errors++; $display("FAIL rmf_fill: got %b want 1", iREN); end
        @(negedge CLK);
        iwait = 1'b0; iload = memw(32'h3C0); nRST = 1'b0; imemREN = 1'b0;
        #1;
        vectors++; if (iREN !== 1'b1) begin errors++; $display("FAIL rmf_fill_hold: got %b want 1", iREN); end
        @(negedge CLK);
        nRST = 1'b1; iwait = 1'b1;
        #1;
        vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL rmf_iREN: got %b want 0", iREN); end
        vectors++; if (hit_count !== '0) begin errors++; $display("FAIL rmf_hits: got %0d want 0", hit_count); end
        vectors++; if (miss_count !== '0) begin errors++; $display("FAIL rmf_misses: got %0d want 0", miss_count); end
        model_clear();
        do_fetch(32'h3C0, 1, 1'b0, 32'h0);
        do_fetch(32'h40, 0, 1'b0, 32'h0);
    endtask

    task automatic test_halt();
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h40; halt = 1'b1;
        #1;
        vectors++; if (ihit !== 1'b0) begin errors++; $display("FAIL halt_ihit: got %b want 0", ihit); end
        vectors++; if (imemload !== 32'h0) begin errors++; $display("FAIL halt_data: got %08h want 0", imemload); end
        @(negedge CLK);
        imemaddr = 32'h7C0;
        #1;
        vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL halt_iREN: got %b want 0", iREN); end
        @(negedge CLK); #1;
        vectors++; if (iREN !== 1'b0) begin errors++; $display("FAIL halt_nofill: got %b want 0", iREN); end
        vectors++; if (miss_count !== CNT_W'(mmisses)) begin errors++;
            $display("FAIL halt_misses: got %0d want %0d", miss_count, mmisses); end
        halt = 1'b0; imemREN = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        for (int n = 0; n < 250; n++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) a = a | 32'h8000_0000;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                @(negedge CLK);
                imemREN = 1'b0; halt = 1'(($urandom_range(0, 1))); imemaddr = a;
                #1;
                vectors++; if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
                    errors++;
                    $display("FAIL rand_idle: ihit=%b iREN=%b iaddr=%08h imemload=%08h want all 0",
                             ihit, iREN, iaddr, imemload);
                end
                halt = 1'b0;
            end else if (r == 1) begin
                @(negedge CLK);
                imemREN = 1'b1; halt = 1'b1; imemaddr = a;
                #1;
                vectors++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++;
                    $display("FAIL rand_halt: ihit=%b iREN=%b want 0 0", ihit, iREN); end
                halt = 1'b0; imemREN = 1'b0;
            end else begin
                do_fetch(a, $urandom_range(0, 3), 1'b0, 32'h0);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) do_fetch(32'h40, 0, 1'b0, 32'h0);
        @(negedge CLK); imemREN = 1'b0; #1;
        vectors++; if (hit_count !== '1) begin errors++;
            $display("FAIL hit_saturate: got %0d want %0d", hit_count, CMAX); end
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_repeat_hits();
        test_conflict();
        test_addr_change();
        test_reset_mid_fill();
        test_halt();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
